// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver slice.
// Optional even-parity support is selected with the UART_RX_PARITY_EN macro.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_rx_state_t;

    // 2-of-3 majority used to vote each bit at its centre
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Host-side holding-register interface of the UART receiver.
//
// Handshake: rx_valid means rx_data holds a byte nobody has taken yet.
// A transfer happens on a clk edge where rx_valid & rx_ready are both 1.
// rx_valid never waits for rx_ready; a new byte arriving while rx_valid is
// still set (and not consumed that same cycle) replaces it and pulses
// overrun for one clk. rx_data and the error flags stay put after a
// transfer until the next byte loads.
interface uart_rx_if;
    import uart_pkg::*;

    logic [UART_DATA_BITS-1:0] rx_data;
    logic                      rx_valid;
    logic                      rx_ready;
    logic                      frame_err;
    logic                      parity_err;
    logic                      overrun;

    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous, idle-high input.
// Resets to 1 so a freshly reset line looks idle.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // shift the async input through two flops
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, 1 stop bit, majority vote at each
// bit centre on the oversampling tick, bytes handed over through a
// valid/ready holding register.
// Define UART_RX_PARITY_EN to add one even-parity bit before the stop bit.
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           os_tick,
    input  logic           rx,
    uart_rx_if.master      host,
    output logic           busy,
    output uart_rx_state_t dbg_state
);

    localparam int              CW       = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0]   CNT_A    = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0]   CNT_B    = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0]   CNT_V    = CW'(OVERSAMPLE / 2 + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]      LAST_BIT = 3'(UART_DATA_BITS - 1);

    uart_rx_state_t            state, next_state;
    logic                      rx_s;
    logic [CW-1:0]             os_cnt;
    logic [2:0]                bit_cnt;
    logic                      s0, s1;
    logic                      armed;
    logic [UART_DATA_BITS-1:0] shreg;
    logic                      at_a, at_b, at_vote, at_wrap;
    logic                      vote, start_det, load;

    logic [UART_DATA_BITS-1:0] data_q;
    logic                      valid_q, ferr_q, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic                      par_bit;
    logic                      perr_q;
`endif

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // next-state decode: START aborts on a high vote, STOP ends at its vote
    always_comb begin
        next_state = state;
        case (state)
            IDLE:   if (start_det) next_state = START;
            START: begin
                if (at_vote && vote) next_state = IDLE;
                else if (at_wrap)    next_state = DATA;
            end
            DATA: begin
`ifdef UART_RX_PARITY_EN
                if (at_wrap && bit_cnt == LAST_BIT) next_state = PARITY;
`else
                if (at_wrap && bit_cnt == LAST_BIT) next_state = STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (at_wrap) next_state = STOP;
`endif
            STOP:   if (at_vote) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // sample-point strobes, bit vote and state-derived outputs
    always_comb begin
        at_a      = os_tick && (os_cnt == CNT_A);
        at_b      = os_tick && (os_cnt == CNT_B);
        at_vote   = os_tick && (os_cnt == CNT_V);
        at_wrap   = os_tick && (os_cnt == CNT_LAST);
        vote      = maj3(s0, s1, rx_s);
        start_det = (state == IDLE) && os_tick && armed && !rx_s;
        load      = (state == STOP) && at_vote;
        busy      = (state != IDLE);
        dbg_state = state;
    end

    // bit timing, centre samples, data shift register and re-arm tracking;
    // the start-detect tick is position 0 of the start bit, so the counter
    // leaves IDLE already at 1
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            os_cnt  <= '0;
            bit_cnt <= '0;
            s0      <= 1'b1;
            s1      <= 1'b1;
            armed   <= 1'b0;
            shreg   <= '0;
`ifdef UART_RX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else if (state == IDLE) begin
            os_cnt  <= start_det ? CW'(1) : '0;
            bit_cnt <= '0;
            if (os_tick && rx_s) armed <= 1'b1;
        end else if (os_tick) begin
            os_cnt <= (os_cnt == CNT_LAST) ? '0 : os_cnt + CW'(1);
            if (at_a) s0 <= rx_s;
            if (at_b) s1 <= rx_s;
            if (state == DATA && at_vote) shreg   <= {vote, shreg[UART_DATA_BITS-1:1]};
            if (state == DATA && at_wrap) bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
            if (state == PARITY && at_vote) par_bit <= vote;
`endif
            // a low stop bit (e.g. a break) must see the line high again
            if (load) armed <= vote;
        end
    end

    // host holding register: load at the stop vote, clear on consume
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            overrun_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            overrun_q <= load && valid_q && !host.rx_ready;
            if (load) begin
                data_q  <= shreg;
                valid_q <= 1'b1;
                ferr_q  <= ~vote;
`ifdef UART_RX_PARITY_EN
                perr_q  <= (^shreg) ^ par_bit;
`endif
            end else if (valid_q && host.rx_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign host.rx_data   = data_q;
    assign host.rx_valid  = valid_q;
    assign host.frame_err = ferr_q;
    assign host.overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign host.parity_err = perr_q;
`else
    assign host.parity_err = 1'b0;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver: recovers bytes from the asynchronous serial line driven by the team's `uart_tx` (8 data bits, LSB first, 1 stop bit). It samples the line on an oversampling tick from the shared baud generator and majority-votes each bit at its centre. Received bytes are presented to the host side through a valid/ready holding register, with framing, overrun and optional parity flags.

## Interface
- `OVERSAMPLE`, 16: `os_tick` pulses per bit period; even, ≥ 8. M = OVERSAMPLE/2.
- `clk`  in  1  single clock; all logic on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `os_tick`  in  1  one-`clk` pulse at OVERSAMPLE × baud rate.
- `rx`  in  1  asynchronous serial input; idle high.
- `rx_ready`  in  1  consumer accepts `rx_data` when `rx_valid & rx_ready` at a `clk` edge.
- `rx_data`  out  8  last received byte, held until replaced.
- `rx_valid`  out  1  `rx_data` holds an unconsumed byte.
- `frame_err`  out  1  stop bit sampled 0 for the byte in `rx_data`.
- `parity_err`  out  1  parity mismatch for the byte in `rx_data`; tied 0 when parity is compiled out.
- `overrun`  out  1  one-`clk` pulse when an unconsumed byte is overwritten.
- `busy`  out  1  state ≠ IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer (reset value 1) to give `rx_s`. All sampling uses `rx_s` and only on `os_tick` cycles.
- `os_cnt` counts 0..OVERSAMPLE-1 per bit, advancing on `os_tick` and wrapping to 0 at each bit boundary. Samples are taken at os_cnt = M-1, M and M+1; the vote (2-of-3) is formed at M+1.
- Arming: IDLE accepts a start only after `rx_s`=1 has been seen on an `os_tick`. This prevents a held-low break from retriggering.
- States:
  - IDLE → START: on an `os_tick` with `rx_s`=0 while armed; os_cnt=0.
  - START: vote=1 is a false start → IDLE, with no flags and no output. Otherwise → DATA at os_cnt wrap.
  - DATA: vote is shifted into bit 7 of a shift register (right shift, LSB first). After the 8th bit wraps → PARITY (if compiled in) or STOP.
  - PARITY: even parity; the vote is stored in `par_bit`. → STOP at wrap.
  - STOP: at the vote (os_cnt = M+1, no wait for wrap), load the outputs and go → IDLE, with armed = vote.
- Load at the STOP vote: `rx_data` ← shift register; `rx_valid` ← 1; `frame_err` ← ~vote; `parity_err` ← parity mismatch. A framing error still delivers the byte.
- Consume: `rx_valid & rx_ready` clears `rx_valid`. The data and error flags keep their values.
- Simultaneous load and consume: the new byte loads, `rx_valid` stays 1, and `overrun` is not pulsed.
- Load while `rx_valid`=1 and not consumed in the same cycle: overwrite the byte and pulse `overrun`.

## Timing
- Reset values (the cycle after `rst_n`=0 at a `clk` edge):
  - `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
  - State = IDLE, armed=0, synchronizer flops = 1.
- Reset mid-frame aborts the frame with no output.
- Input latency: 2 `clk` cycles for the synchronizer.
- Output latency, measured from the start-detect `os_tick`, for N data bits plus P parity bits (N=8):
  - The STOP vote occurs at `os_tick` number (9+P)·OVERSAMPLE + M + 1.
  - `rx_valid`, `rx_data` and the flags update on the `clk` edge following that `os_tick` cycle.
- Back-to-back frames: a start edge arriving at or after the STOP vote is captured. Tolerance is roughly ±(M-1)/OVERSAMPLE bit of accumulated drift.
- `rx_ready` is accepted combinationally in the same cycle. There is no bubble after a consume.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state: one even-parity bit between data and stop.
  - `parity_err` = XOR of the 8 data bits and `par_bit`.
- `UART_RX_PARITY_EN` undefined:
  - The frame is 8N1, matching `uart_tx`.
  - The PARITY state and `par_bit` are absent.
  - `parity_err` is driven constant 0.

## Structure
- Package `uart_pkg`:
  - State enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - `UART_DATA_BITS`=8.
  - Default `UART_OVERSAMPLE`=16.
- Sub-module `uart_rx_sync`: 2-flop synchronizer with reset value 1. It is reusable by other async inputs.

## Test plan
- Reset with `rx`=1 → all outputs are at their reset values and `busy`=0. Assert `rst_n`=0 mid-frame during DATA → no `rx_valid`; the next frame receives correctly.
- Send 0xA5 8N1 at OVERSAMPLE=16 with `rx_ready`=1 → `rx_valid` for 1 cycle, `rx_data`=0xA5, `frame_err`=0, and the latency matches Timing.
- `rx` low for 4 `os_tick`s, then high → START false-start → IDLE; no `rx_valid`; `busy` high only during the glitch.
- 0x3C with stop bit 0, then `rx` held low for 30 bit times → one delivery: `rx_data`=0x3C, `frame_err`=1. No further frames until `rx` returns high.
- 0x11 then 0x22 back-to-back with `rx_ready`=0 → second load gives `overrun` pulse and `rx_data`=0x22. Repeat with `rx_ready` asserted in the load cycle → no `overrun`.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 → `parity_err`=1; with parity bit 1 → `parity_err`=0. Without the macro: the 0xA5 8N1 case passes and `parity_err` stays 0.
